trace_uart_streamer: RTL and testbench

Retire-trace serializer downstream of the `riscv_wishbone` core. Captures each retired instruction word and its result from the core's trace outputs, buffers them in a small FIFO, and streams them as 9-byte frames over an 8N1 UART line. Gives silicon and FPGA builds the same instruction/result log the simulation bench writes to file, including the fail-marker check.

---
 rtl/trace_uart_streamer.sv | 215 +++++++++++++++++++++
 tb/tb_trace_uart_streamer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_uart_streamer.sv
// Retire-trace serializer: buffers {instr, result} pairs and streams each as a 9-byte 8N1 UART frame.
// Define TRACE_FAIL_DETECT_EN to tag the test-fail marker instruction (header 0xEE, sticky fail_o).
module trace_uart_streamer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        valid_i,
  input  logic [31:0]                 instr_i,
  input  logic [31:0]                 result_i,
  output logic                        uart_tx,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        overflow_o,
  output logic [7:0]                  drop_cnt_o,
  output logic                        fail_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(CLKS_PER_BIT);

  localparam logic [7:0]  HDR_NORMAL = 8'hA5;
`ifdef TRACE_FAIL_DETECT_EN
  localparam logic [7:0]  HDR_FAIL    = 8'hEE;
  localparam logic [31:0] FAIL_MARKER = 32'h001e6e13;
  localparam int unsigned EW          = 65;
`else
  localparam int unsigned EW          = 64;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    byte_q, byte_d;
  logic [71:0]   shreg_q, shreg_d;
  logic [7:0]    cur_byte;
  logic [7:0]    header;
  logic          tmr_done;
  logic          tx_q, tx_d;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == PW'(FIFO_DEPTH));
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign push_ok    = valid_i && (!fifo_full || pop);
  assign drop       = valid_i && fifo_full && !pop;
  assign rd_entry   = mem_q[rd_ptr_q[AW-1:0]];

`ifdef TRACE_FAIL_DETECT_EN
  logic fail_q, fail_d;

  assign wr_entry = {(instr_i == FAIL_MARKER), instr_i, result_i};
  assign header   = rd_entry[64] ? HDR_FAIL : HDR_NORMAL;
  assign fail_d   = fail_q | (push_ok && (instr_i == FAIL_MARKER));
  assign fail_o   = fail_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fail_q <= 1'b0;
    end else begin
      fail_q <= fail_d;
    end
  end
`else
  assign wr_entry = {instr_i, result_i};
  assign header   = HDR_NORMAL;
  assign fail_o   = 1'b0;
`endif

  // Storage has no reset; emptying the FIFO only needs the pointers cleared.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{(PW-1){1'b0}}, push_ok};
    rd_ptr_d   = rd_ptr_q + {{(PW-1){1'b0}}, pop};
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign tmr_done = (tmr_q == TW'(CLKS_PER_BIT - 1));
  assign cur_byte = shreg_q[71:64];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_START;
      S_START: if (tmr_done) state_d = S_DATA;
      S_DATA:  if (tmr_done && (bit_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (tmr_done) state_d = (byte_q < 4'd8) ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shift register holds the frame MSB-byte first; each byte leaves LSB first.
  always_comb begin
    tmr_d   = (state_q == S_IDLE || tmr_done) ? '0 : tmr_q + TW'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    case (state_q)
      S_IDLE: begin
        bit_d  = '0;
        byte_d = '0;
        if (pop) begin
          shreg_d = {header, rd_entry[63:0]};
        end
      end
      S_DATA: begin
        if (tmr_done) begin
          bit_d = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tmr_done) begin
          if (byte_q < 4'd8) begin
            byte_d  = byte_q + 4'd1;
            shreg_d = {shreg_q[63:0], 8'h00};
          end else begin
            byte_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // Line level is computed from the next state so uart_tx is a true flop output.
  always_comb begin
    busy_o = (state_q != S_IDLE);
    tx_d   = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx      = tx_q;
  assign fifo_count_o = count;
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_trace_uart_streamer.sv
// Directed bench for trace_uart_streamer: decodes the UART line and compares frames, timing and FIFO flags.
`timescale 1ns/1ps
module tb_trace_uart_streamer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef TRACE_FAIL_DETECT_EN
  localparam logic [7:0] HDR_MARK = 8'hEE;
  localparam logic       EXP_FAIL = 1'b1;
`else
  localparam logic [7:0] HDR_MARK = 8'hA5;
  localparam logic       EXP_FAIL = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic [31:0] result_i = '0;
  logic        uart_tx;
  logic        busy_o;
  logic [2:0]  fifo_count_o;
  logic        overflow_o;
  logic [7:0]  drop_cnt_o;
  logic        fail_o;

  int n_checks = 0;
  int n_pass   = 0;
  int rst_gen  = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  int t2_cnt [3]  = '{1, 1, 2};
  int t3_cnt [10] = '{1, 1, 2, 3, 4, 4, 4, 4, 4, 4};

  trace_uart_streamer #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .valid_i     (valid_i),
    .instr_i     (instr_i),
    .result_i    (result_i),
    .uart_tx     (uart_tx),
    .busy_o      (busy_o),
    .fifo_count_o(fifo_count_o),
    .overflow_o  (overflow_o),
    .drop_cnt_o  (drop_cnt_o),
    .fail_o      (fail_o)
  );

  always #5 CLK = ~CLK;

  always @(posedge RST) rst_gen++;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // UART receiver: samples each bit mid-way; bytes cut short by a reset are discarded.
  initial begin
    logic [7:0] rb;
    logic       stop_v;
    int         gen;
    forever begin
      @(negedge CLK);
      if (!RST && uart_tx === 1'b0) begin
        gen = rst_gen;
        repeat (CPB / 2) @(negedge CLK);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge CLK);
          rb[b] = uart_tx;
        end
        repeat (CPB) @(negedge CLK);
        stop_v = uart_tx;
        if (gen == rst_gen) begin
          check_val("stop_bit", stop_v, 1);
          rx_q.push_back(rb);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] res);
    valid_i  = v;
    instr_i  = ins;
    result_i = res;
    @(negedge CLK);
  endtask

  task automatic exp_frame(input logic [7:0] hdr, input logic [31:0] ins, input logic [31:0] res);
    exp_q.push_back(hdr);
    for (int i = 3; i >= 0; i--) exp_q.push_back(ins[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(res[i*8 +: 8]);
  endtask

  task automatic wait_busy(input logic lvl, input int limit, output int n);
    n = 0;
    while (busy_o !== lvl && n < limit) begin
      @(negedge CLK);
      n++;
    end
    check_val("busy_level", busy_o, lvl);
  endtask

  task automatic check_rx(input string tag, input int limit);
    int n = 0;
    int nb;
    while (rx_q.size() < exp_q.size() && n < limit) begin
      @(negedge CLK);
      n++;
    end
    check_val({tag, "_len"}, rx_q.size(), exp_q.size());
    nb = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < nb; i++) check_val(tag, rx_q[i], exp_q[i]);
    for (int f = 0; f * 9 + 8 < nb; f++)
      $display("%s frame %0d: %02h %02h%02h%02h%02h %02h%02h%02h%02h", tag, f,
               rx_q[f*9], rx_q[f*9+1], rx_q[f*9+2], rx_q[f*9+3], rx_q[f*9+4],
               rx_q[f*9+5], rx_q[f*9+6], rx_q[f*9+7], rx_q[f*9+8]);
    rx_q.delete();
    exp_q.delete();
    wait_busy(1'b0, 200, n);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (50) @(negedge CLK);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;

    @(negedge CLK);
    check_val("rst_tx", uart_tx, 1);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_count", fifo_count_o, 0);
    check_val("rst_overflow", overflow_o, 0);
    check_val("rst_drop", drop_cnt_o, 0);
    check_val("rst_fail", fail_o, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Single frame: latency, bit-exact bytes, 90*CPB duration.
    drive(1'b1, 32'h00500093, 32'h00000005);
    check_val("t1_count", fifo_count_o, 1);
    check_val("t1_busy_pre", busy_o, 0);
    drive(1'b0, '0, '0);
    check_val("t1_tx_start", uart_tx, 0);
    check_val("t1_busy", busy_o, 1);
    check_val("t1_popped", fifo_count_o, 0);
    wait_busy(1'b0, 1000, n);
    check_val("t1_frame_len", n, 90 * CPB);
    exp_frame(8'hA5, 32'h00500093, 32'h00000005);
    check_rx("t1_byte", 100);

    // Three back-to-back pushes: ordering and one idle cycle between frames.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC0DE0000 | 32'(i), 32'h12345600 | 32'(i));
      check_val("t2_count", fifo_count_o, t2_cnt[i]);
      exp_frame(8'hA5, 32'hC0DE0000 | 32'(i), 32'h12345600 | 32'(i));
    end
    drive(1'b0, '0, '0);
    wait_busy(1'b0, 1000, n);
    wait_busy(1'b1, 10, n);
    check_val("t2_gap1", n, 1);
    wait_busy(1'b0, 1000, n);
    wait_busy(1'b1, 10, n);
    check_val("t2_gap2", n, 1);
    check_rx("t2_byte", 2000);

    // Ten pushes into a depth-4 FIFO: five accepted, five dropped.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hA0000000 | 32'(i), 32'hB0000000 | 32'(i));
      check_val("t3_count", fifo_count_o, t3_cnt[i]);
      if (i < 5) exp_frame(8'hA5, 32'hA0000000 | 32'(i), 32'hB0000000 | 32'(i));
    end
    drive(1'b0, '0, '0);
    check_val("t3_drop", drop_cnt_o, 5);
    check_val("t3_overflow", overflow_o, 1);
    check_rx("t3_byte", 3000);

    // Full FIFO with a pop on the push edge: push accepted, no drop.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0F000000 | 32'(i), 32'h0E000000 | 32'(i));
      exp_frame(8'hA5, 32'h0F000000 | 32'(i), 32'h0E000000 | 32'(i));
    end
    drive(1'b0, '0, '0);
    check_val("t4_full", fifo_count_o, 4);
    wait_busy(1'b0, 1000, n);
    drive(1'b1, 32'h0F0000FF, 32'h0E0000FF);
    exp_frame(8'hA5, 32'h0F0000FF, 32'h0E0000FF);
    check_val("t4_count", fifo_count_o, 4);
    check_val("t4_drop", drop_cnt_o, 5);
    check_val("t4_busy", busy_o, 1);
    drive(1'b0, '0, '0);
    check_rx("t4_byte", 3000);

    // 300 pushes against a frame in flight: drop counter saturates.
    do_reset();
    for (int i = 0; i < 300; i++) drive(1'b1, 32'h55000000 | 32'(i), 32'(i));
    drive(1'b0, '0, '0);
    check_val("t5_drop_sat", drop_cnt_o, 255);
    check_val("t5_overflow", overflow_o, 1);
    check_val("t5_count", fifo_count_o, 4);
    do_reset();

    // Fail marker tagging.
    check_val("t6_fail_pre", fail_o, 0);
    drive(1'b1, 32'h001e6e13, 32'h00000007);
    check_val("t6_fail_set", fail_o, EXP_FAIL);
    drive(1'b1, 32'h00500093, 32'h00000001);
    drive(1'b0, '0, '0);
    exp_frame(HDR_MARK, 32'h001e6e13, 32'h00000007);
    exp_frame(8'hA5, 32'h00500093, 32'h00000001);
    check_rx("t6_byte", 2000);
    check_val("t6_fail_hold", fail_o, EXP_FAIL);

    // Reset during the data bits of byte 4 (instr LSB 0x00 keeps the line low).
    for (int i = 0; i < 6; i++) drive(1'b1, 32'hAB00CD00, 32'h600D0000 | 32'(i));
    drive(1'b0, '0, '0);
    check_val("t7_overflow_pre", overflow_o, 1);
    n = 0;
    while (rx_q.size() < 4 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    check_val("t7_bytes_pre", rx_q.size(), 4);
    repeat (12) @(negedge CLK);
    check_val("t7_tx_mid", uart_tx, 0);
    check_val("t7_busy_mid", busy_o, 1);
    #2;
    RST = 1'b1;
    #1;
    check_val("t7_rst_tx", uart_tx, 1);
    check_val("t7_rst_busy", busy_o, 0);
    check_val("t7_rst_count", fifo_count_o, 0);
    check_val("t7_rst_overflow", overflow_o, 0);
    check_val("t7_rst_drop", drop_cnt_o, 0);
    check_val("t7_rst_fail", fail_o, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (50) @(negedge CLK);
    rx_q.delete();
    exp_q.delete();
    drive(1'b1, 32'h12345678, 32'h9ABCDEF0);
    drive(1'b0, '0, '0);
    exp_frame(8'hA5, 32'h12345678, 32'h9ABCDEF0);
    check_rx("t7_byte", 1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
